pe_rr_arbiter: RTL
==================

# pe_rr_arbiter

Sequential 4-requester arbiter built around the 4x2 priority-encoding function. It grants a single shared resource to one of four requesters, in either fixed-priority or round-robin order. It holds each grant until the requester signals `done`, withdraws its request, or a hold timeout expires. The grant index and valid outputs use the same `{y1,y0}`/`v` encoding as the priority encoder, so downstream muxes and checkers reuse that convention.

## Interface
Parameters:
- `HOLD_MAX`, default 16: maximum number of cycles a grant may be held. Value 0 disables the timeout.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request lines; `req[3]` ↔ encoder input a3.
- `done`  input  1  release strobe from the currently granted requester.
- `mode`  input  1  0 = fixed priority (3 highest), 1 = round-robin.
- `gnt`  output  4  one-hot grant, registered.
- `gnt_idx`  output  2  encoded grant index `{y1,y0}`, registered.
- `gnt_v`  output  1  grant valid (`v`), registered; equals `|gnt`.
- `timeout`  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States: IDLE, GRANT, RELEASE.
- **IDLE:** if `req != 0`, arbitrate and go to GRANT. Otherwise stay.
- **GRANT:** the granted requester keeps the grant. Leave to RELEASE when any of the following is true:
  - `done == 1`;
  - `req[gnt_idx] == 0` (withdrawal);
  - `hold_cnt == HOLD_MAX` with `HOLD_MAX != 0`, which also fires `timeout`.
- **RELEASE:** the grant is forced to 0 for exactly one cycle. If `req != 0`, arbitrate and go to GRANT. Otherwise go to IDLE.
- **Arbitration rules:**
  - `mode` is sampled only at the arbitration cycle.
  - Fixed mode: highest set index wins, i.e. 3 > 2 > 1 > 0.
  - Round-robin mode: search ascending from `(last+1) mod 4`; the first set bit wins.
- **`last` pointer:** 2-bit register updated to the winning index on every grant, in both modes. Reset value 3, so the first round-robin order is 0, 1, 2, 3.
- **Hold counter:**
  - Width is `$clog2(HOLD_MAX+1)`, minimum 1 bit.
  - Loads 1 on entry to GRANT and increments each cycle the state remains in GRANT.
  - Saturates and never wraps.
- **Simultaneous events:** if `done` and the timeout coincide, `done` takes precedence and `timeout` stays 0. Withdrawal is treated as `done`.
- Changes to requests other than the granted one have no effect during GRANT.
- Invariants: `gnt` is at most one-hot; `gnt_v == |gnt`; `gnt == (1 << gnt_idx)` whenever `gnt_v == 1`.

## Timing
- **Reset values:** state = IDLE; `gnt` = 4'b0000; `gnt_idx` = 2'b00; `gnt_v` = 0; `timeout` = 0; `last` = 3; `hold_cnt` = 0.
- **Reset mid-grant:** all outputs clear immediately (asynchronous). Operation resumes on the first rising edge after `rst` deasserts.
- **Request-to-grant latency:** `req` sampled in IDLE at edge t produces the grant at t+1.
- **Release timing:** `done` sampled at edge t drops `gnt` at t+1 (RELEASE). The next grant, if requests are pending, appears at t+2.
- **Back-to-back gap:** consecutive grants are separated by exactly one zero-grant cycle.
- **Timeout timing:** for a grant first visible at edge g, with no `done`:
  - `timeout` pulses and `gnt` drops at edge g+HOLD_MAX;
  - the resulting hold is HOLD_MAX cycles.
- `timeout` is registered and high for one cycle, aligned with the RELEASE cycle.

## Structure
- Package `pe_arb_pkg`:
  - `NREQ = 4`;
  - `typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t`;
  - `typedef logic [1:0] idx_t`.
- Sub-module `pe_rr_pick` (combinational): inputs `req`, `last`, `mode`; outputs winner `idx_t` and `any`.
  - Implemented as rotate, then 4x2 priority encode (lowest-first in round-robin mode), then un-rotate.
  - Fixed mode bypasses the rotation and uses 3-highest priority.
- Top level: FSM, `last` register, hold counter, output registers.
- Bind-style immediate and concurrent assertion checker `pe_arb_assertion` covering the invariants above.

## Test plan
- **Reset:** `rst` pulsed mid-grant while `gnt` = 4'b0100 → outputs go to 0 asynchronously; after release, `req` = 4'b0001 → `gnt` = 4'b0001, `gnt_idx` = 0 one cycle later.
- **Fixed priority:** `mode` = 0, `req` = 4'b1011 → `gnt_idx` = 3. After `done`: one idle cycle, then `gnt_idx` = 1 with `req` = 4'b0011.
- **Round-robin fairness:** `mode` = 1, `req` = 4'b1111 held, `done` pulsed each grant → grant order 0, 1, 2, 3, 0, each separated by one zero-grant cycle.
- **Timeout:** `HOLD_MAX` = 4, `req` = 4'b0010, no `done` → `gnt` high for 4 cycles, then `timeout` = 1 for one cycle with `gnt` = 0; re-grant to 1 on the next cycle.
- **Withdrawal and coincidence:**
  - `req[2]` drops during its grant → RELEASE next cycle, `timeout` = 0;
  - `done` on the same cycle the hold limit is reached → `timeout` stays 0.
- **Mode switch:** `mode` toggled 0→1 during GRANT → no effect until the next arbitration, which uses round-robin from `last+1`.

Source files
------------

// File: rtl/pe_arb_pkg.sv
// Shared types and the 4x2 priority-encoder helpers for the pe_rr_arbiter slice.
package pe_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

    typedef logic [1:0] idx_t;

    typedef struct packed {
        idx_t y;
        logic v;
    } pe_out_t;

    // 4x2 priority encoder, a[3] highest; y is 0 when nothing is set.
    function automatic pe_out_t pe4x2(input logic [NREQ-1:0] a);
        pe_out_t r;
        r.v = |a;
        if (a[3])      r.y = 2'd3;
        else if (a[2]) r.y = 2'd2;
        else if (a[1]) r.y = 2'd1;
        else           r.y = 2'd0;
        return r;
    endfunction

    function automatic logic [NREQ-1:0] bit_rev(input logic [NREQ-1:0] a);
        logic [NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i] = a[NREQ-1-i];
        return r;
    endfunction

endpackage

// File: rtl/pe_arb_assertion.sv
// Invariant checker for pe_rr_arbiter outputs, intended to be bound onto the top.
module pe_arb_assertion
    import pe_arb_pkg::*;
(
    input logic            clk,
    input logic            rst,
    input logic [NREQ-1:0] gnt,
    input idx_t            gnt_idx,
    input logic            gnt_v,
    input logic            timeout
);

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt)) else $error("gnt not one-hot: %b", gnt);
            assert (gnt_v == |gnt) else $error("gnt_v %b disagrees with gnt %b", gnt_v, gnt);
        end
    end

    a_idx_match: assert property (@(posedge clk) disable iff (rst)
        gnt_v |-> (gnt == (NREQ'(1) << gnt_idx)));

    a_to_no_grant: assert property (@(posedge clk) disable iff (rst)
        timeout |-> !gnt_v);

    a_to_single: assert property (@(posedge clk) disable iff (rst)
        timeout |=> !timeout);

endmodule

// File: rtl/pe_rr_pick.sv
// Combinational winner selection: fixed 3-highest priority, or round-robin
// starting at last+1 (rotate, lowest-first encode, un-rotate).
module pe_rr_pick
    import pe_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  idx_t            last,
    input  logic            mode,
    output idx_t            winner,
    output logic            any
);

    idx_t              start;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    pe_out_t           fix_enc;
    pe_out_t           rr_enc;
    idx_t              rr_lo;

    assign start = last + idx_t'(1);
    assign dbl   = {req, req} >> start;
    assign rot   = dbl[NREQ-1:0];

    // Lowest-first encoding is the highest-first encoder applied to the mirrored vector.
    assign rr_enc  = pe4x2(bit_rev(rot));
    assign rr_lo   = idx_t'(2'd3) - rr_enc.y;
    assign fix_enc = pe4x2(req);

    assign any    = |req;
    assign winner = mode ? idx_t'(rr_lo + start) : fix_enc.y;

endmodule

// File: rtl/pe_rr_arbiter.sv
// 4-requester arbiter: fixed or round-robin pick, grant held until done,
// withdrawal or hold timeout, with a one-cycle zero-grant RELEASE gap.
module pe_rr_arbiter
    import pe_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    input  logic            mode,
    output logic [NREQ-1:0] gnt,
    output idx_t            gnt_idx,
    output logic            gnt_v,
    output logic            timeout
);

    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t HOLD_LIM = cnt_t'(HOLD_MAX);

    arb_state_t      state, state_nxt;
    idx_t            last, last_nxt;
    cnt_t            hold_cnt, hold_nxt;
    logic [NREQ-1:0] gnt_nxt;
    idx_t            idx_nxt;
    logic            v_nxt;
    logic            to_nxt;

    idx_t            pick_idx;
    logic            pick_any;
    logic            owner_drop;
    logic            hold_hit;

    pe_rr_pick u_pick (
        .req    (req),
        .last   (last),
        .mode   (mode),
        .winner (pick_idx),
        .any    (pick_any)
    );

    // Withdrawal behaves exactly like done, so both outrank the timeout.
    assign owner_drop = done | ~req[gnt_idx];
    assign hold_hit   = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        v_nxt     = gnt_v;
        to_nxt    = 1'b0;

        case (state)
            IDLE, RELEASE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                v_nxt     = 1'b0;
                hold_nxt  = '0;
                if (pick_any) begin
                    state_nxt = GRANT;
                    gnt_nxt   = NREQ'(1) << pick_idx;
                    idx_nxt   = pick_idx;
                    v_nxt     = 1'b1;
                    last_nxt  = pick_idx;
                    hold_nxt  = cnt_t'(1);
                end
            end
            GRANT: begin
                if (owner_drop || hold_hit) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = '0;
                    idx_nxt   = '0;
                    v_nxt     = 1'b0;
                    hold_nxt  = '0;
                    to_nxt    = ~owner_drop;
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + cnt_t'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                v_nxt     = 1'b0;
                hold_nxt  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= idx_t'(2'd3);
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_v    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= idx_nxt;
            gnt_v    <= v_nxt;
            timeout  <= to_nxt;
        end
    end

endmodule
